// File: rtl/shifter_issue_stage.sv
// rtl/shifter_issue_stage.sv - issue FIFO presenting the head shift request to the barrel shifter chain
// Optional issue counter: SHIFTER_ISSUE_CNT_EN
module shifter_issue_stage #(
    parameter int DATA_W = 32,
    parameter int AMT_W  = 5,
    parameter int DEPTH  = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic              IN_DIR,
    input  logic [AMT_W-1:0]  IN_AMT,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              SH_DIR,
    output logic [AMT_W-1:0]  SH_AMT,
    output logic [DATA_W-1:0] D_IN,
    output logic              BUSY,
    output logic [15:0]       ISSUE_CNT
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = 1 + AMT_W + DATA_W;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_in_ready;

    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [OCC_W-1:0] w_occ_nxt;
    logic [ENT_W-1:0] w_head;

    assign w_out_valid = (r_occ != '0);
    assign w_push      = IN_VALID & r_in_ready;
    assign w_pop       = w_out_valid & OUT_READY;

    always_comb begin
        w_occ_nxt = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_nxt = r_occ + 1'b1;
            2'b01:   w_occ_nxt = r_occ - 1'b1;
            default: w_occ_nxt = r_occ;
        endcase
    end

    // Ready is registered, so a full FIFO cannot accept in the cycle it pops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_occ      <= w_occ_nxt;
            r_in_ready <= (w_occ_nxt < DEPTH_OCC);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= {IN_DIR, IN_AMT, IN_DATA};
    end

    // Empty FIFO drives zeros so the shifter never sees a stale head.
    assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

    assign SH_DIR    = w_head[ENT_W-1];
    assign SH_AMT    = w_head[DATA_W +: AMT_W];
    assign D_IN      = w_head[DATA_W-1:0];
    assign OUT_VALID = w_out_valid;
    assign BUSY      = w_out_valid;
    assign IN_READY  = r_in_ready;

`ifdef SHIFTER_ISSUE_CNT_EN
    logic [15:0] r_issue_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_issue_cnt <= 16'h0000;
        end else if (w_pop) begin
            r_issue_cnt <= r_issue_cnt + 16'd1;
        end
    end

    assign ISSUE_CNT = r_issue_cnt;
`else
    assign ISSUE_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_shifter_issue_stage.sv
// tb/tb_shifter_issue_stage.sv - directed self-checking bench for shifter_issue_stage
module tb_shifter_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_dir;
    logic [4:0]  in_amt;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        sh_dir;
    logic [4:0]  sh_amt;
    logic [31:0] d_in;
    logic        busy;
    logic [15:0] issue_cnt;

    int checks   = 0;
    int failures = 0;
    int pops     = 0;

    shifter_issue_stage #(.DATA_W(32), .AMT_W(5), .DEPTH(2)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN_DIR    (in_dir),
        .IN_AMT    (in_amt),
        .IN_DATA   (in_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .SH_DIR    (sh_dir),
        .SH_AMT    (sh_amt),
        .D_IN      (d_in),
        .BUSY      (busy),
        .ISSUE_CNT (issue_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef SHIFTER_ISSUE_CNT_EN
        return n[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy},      32'd0);
        chk({tag, "_dir"},   {31'd0, sh_dir},    32'd0);
        chk({tag, "_amt"},   {27'd0, sh_amt},    32'd0);
        chk({tag, "_din"},   d_in,               32'd0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_dir = 1'b0; in_amt = '0; in_data = '0; out_ready = 1'b0;
        step(); step();
        chk_idle("rst");
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_cnt", {16'd0, issue_cnt}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_pre", {31'd0, in_ready}, 32'd0);
        step();
        chk("rel_ready", {31'd0, in_ready}, 32'd1);

        // single push then pop
        in_valid = 1'b1; in_dir = 1'b1; in_amt = 5'd2; in_data = 32'h8000_0010; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2_valid", {31'd0, out_valid}, 32'd1);
        chk("t2_dir",   {31'd0, sh_dir},    32'd1);
        chk("t2_amt",   {27'd0, sh_amt},    32'd2);
        chk("t2_din",   d_in,               32'h8000_0010);
        step(); pops++;
        chk_idle("t2_empty");
        chk("t2_cnt", {16'd0, issue_cnt}, {16'd0, exp_cnt(pops)});

        // fill to full with downstream stalled
        out_ready = 1'b0; in_valid = 1'b1; in_dir = 1'b0; in_amt = 5'd31; in_data = 32'h1;
        step();
        chk("t3_ready1", {31'd0, in_ready}, 32'd1);
        in_data = 32'h2; in_amt = 5'd7;
        step();
        chk("t3_ready2", {31'd0, in_ready}, 32'd0);
        chk("t3_din", d_in, 32'h1);
        chk("t3_amt", {27'd0, sh_amt}, 32'd31);
        in_data = 32'h3; in_amt = 5'd0;
        step();
        chk("t3_stall_ready", {31'd0, in_ready}, 32'd0);
        chk("t3_stall_din", d_in, 32'h1);
        chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);

        // full with pop and push offered together: pop only
        out_ready = 1'b1;
        step(); pops++;
        chk("t5_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_din", d_in, 32'h2);
        out_ready = 1'b0;
        step();
        chk("t5_push_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_push_din", d_in, 32'h2);
        in_valid = 1'b0; out_ready = 1'b1;
        step(); pops++;
        chk("t5_drain_din", d_in, 32'h3);
        chk("t5_drain_ready", {31'd0, in_ready}, 32'd1);
        step(); pops++;
        chk_idle("t5_empty");
        chk("t5_cnt", {16'd0, issue_cnt}, {16'd0, exp_cnt(pops)});

        // continuous streaming 1..8
        in_valid = 1'b1; out_ready = 1'b1; in_dir = 1'b1; in_amt = 5'd4;
        for (int k = 1; k <= 8; k++) begin
            in_data = k;
            chk("t4_ready", {31'd0, in_ready}, 32'd1);
            step();
            if (k > 1) pops++;
            chk("t4_din", d_in, k);
            chk("t4_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        step(); pops++;
        chk_idle("t4_empty");
        chk("t4_cnt", {16'd0, issue_cnt}, {16'd0, exp_cnt(pops)});

        // reset mid-traffic
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk_idle("t1_rst");
        chk("t1_rst_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_rst_cnt", {16'd0, issue_cnt}, 32'd0);
        pops = 0;
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t1_rel_ready", {31'd0, in_ready}, 32'd1);
        chk_idle("t1_rel");

        // counter wrap
        in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h5;
        for (int i = 0; i < 65535; i++) step();
        in_valid = 1'b0;
        step();
        pops = 65535;
        chk("t6_cnt_ffff", {16'd0, issue_cnt}, {16'd0, exp_cnt(pops)});
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t6_valid", {31'd0, out_valid}, 32'd1);
        step(); pops++;
        chk("t6_cnt_wrap", {16'd0, issue_cnt}, 32'd0);
        chk_idle("t6_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
